// File: rtl/mmio_pkg.sv
// mmio_pkg: shared register map, bit positions and bus encodings for the console TX peripheral.
package mmio_pkg;
    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam logic [1:0] OFF_CTRL   = 2'd3;
    localparam int ST_FULL      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_COUNT_LSB = 8;
    localparam int CTRL_EN      = 0;
    localparam int CTRL_FLUSH   = 1;
    localparam int CB_WE = 0;
    localparam int CB_RE = 1;
    localparam logic [7:0] DEFAULT_BASE_ADDR = 8'hF0;
endpackage

// File: rtl/mmio_console_tx_if.sv
// mmio_console_tx_if: processor bus responder signals plus the outgoing byte stream.
interface mmio_console_tx_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] address_bus;
    logic [DATA_W-1:0] wdata_bus;
    logic [1:0]        control_bus;
    logic [DATA_W-1:0] rdata;
    logic              rsel;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    modport master (output address_bus, wdata_bus, control_bus, tx_ready,
                    input  rdata, rsel, tx_data, tx_valid);
    modport slave  (input  address_bus, wdata_bus, control_bus, tx_ready,
                    output rdata, rsel, tx_data, tx_valid);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; pushes when full and pops when empty are ignored, flush wins.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic push_ok, pop_ok;

    assign full_o  = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_q];

    always_comb begin
        push_ok = push_i && !full_o;
        pop_ok  = pop_i && !empty_o;
        wr_d  = flush_i ? '0 : wr_q + AW'(push_ok);
        rd_d  = flush_i ? '0 : rd_q + AW'(pop_ok);
        cnt_d = flush_i ? '0 : cnt_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) mem_q[wr_q] <= din_i;
    end
endmodule

// File: rtl/mmio_console_tx.sv
// mmio_console_tx: 4-word MMIO window that queues written bytes and drains them onto a byte stream.
module mmio_console_tx
    import mmio_pkg::*;
#(
    parameter int         ADDR_W     = 8,
    parameter int         DATA_W     = 16,
    parameter logic [7:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
    parameter int         FIFO_DEPTH = 8,
    localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
    input logic              clk,
    input logic              reset,
    mmio_console_tx_if.slave bus
);
    logic [1:0]        off;
    logic              hit, we, re, push, pop, flush;
    logic              full, empty;
    logic [CW-1:0]     count;
    logic [DATA_W-1:0] status, rd_val;
    logic              en_q, en_d, ovf_q, ovf_d, rsel_q, rsel_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    assign hit   = bus.address_bus[ADDR_W-1:2] == BASE_ADDR[ADDR_W-1:2];
    assign off   = bus.address_bus[1:0];
    assign we    = hit && bus.control_bus[CB_WE];
    assign re    = hit && bus.control_bus[CB_RE];
    assign push  = we && off == OFF_TXDATA;
    assign flush = we && off == OFF_CTRL && bus.wdata_bus[CTRL_FLUSH];
    assign bus.tx_valid = !empty && en_q;
    assign pop   = bus.tx_valid && bus.tx_ready;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push_i (push),
        .pop_i  (pop),
        .flush_i(flush),
        .din_i  (bus.wdata_bus[7:0]),
        .dout_o (bus.tx_data),
        .full_o (full),
        .empty_o(empty),
        .count_o(count)
    );

    // Read value is taken from pre-edge state, so a same-cycle write is not visible.
    always_comb begin
        status = '0;
        status[ST_COUNT_LSB +: 5] = 5'(count);
        status[ST_OVF]   = ovf_q;
        status[ST_EMPTY] = empty;
        status[ST_FULL]  = full;
        rd_val = off == OFF_TXDATA ? '0 :
                 off == OFF_STATUS ? status :
                 off == OFF_COUNT  ? DATA_W'(count) : DATA_W'(en_q);
        rdata_d = re ? rd_val : rdata_q;
        rsel_d  = re;
        en_d    = we && off == OFF_CTRL ? bus.wdata_bus[CTRL_EN] : en_q;
        ovf_d   = push && full ? 1'b1 :
                  we && off == OFF_STATUS && bus.wdata_bus[ST_OVF] ? 1'b0 : ovf_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q    <= 1'b1;
            ovf_q   <= 1'b0;
            rdata_q <= '0;
            rsel_q  <= 1'b0;
        end else begin
            en_q    <= en_d;
            ovf_q   <= ovf_d;
            rdata_q <= rdata_d;
            rsel_q  <= rsel_d;
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.rsel  = rsel_q;
endmodule

// File: tb/tb_mmio_console_tx.sv
// tb_mmio_console_tx: directed stimulus checked every cycle against a queue-based model of the peripheral.
module tb_mmio_console_tx;
    localparam int DEPTH = 8;
    localparam logic [7:0] BASE = 8'hF0;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mmio_console_tx_if #(.ADDR_W(8), .DATA_W(16)) bus ();

    mmio_console_tx #(.ADDR_W(8), .DATA_W(16), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    int vectors = 0;
    int miscompares = 0;
    bit armed = 1'b0;
    bit rdy_v = 1'b0;

    logic [7:0]  m_q[$];
    bit          m_ovf, m_en, m_rsel;
    logic [15:0] m_rdata;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One bus cycle: drive inputs, predict the post-edge state, wait for the edge, commit.
    task automatic cycle(input bit r, input logic [7:0] a, input logic [15:0] wd, input logic [1:0] cb);
        logic [7:0]  nq[$];
        bit          n_ovf, n_en, n_rsel, we, re, pop;
        logic [15:0] n_rdata, val;
        int          sz;
        reset = r;
        bus.address_bus = a;
        bus.wdata_bus = wd;
        bus.control_bus = cb;
        bus.tx_ready = rdy_v;
        nq = m_q;
        n_ovf = m_ovf;
        n_en = m_en;
        n_rdata = m_rdata;
        n_rsel = 1'b0;
        if (r) begin
            nq = {};
            n_ovf = 1'b0;
            n_en = 1'b1;
            n_rdata = '0;
        end else begin
            we = a[7:2] == BASE[7:2] && cb[0];
            re = a[7:2] == BASE[7:2] && cb[1];
            sz = m_q.size();
            case (a[1:0])
                2'd0: val = 16'h0;
                2'd1: val = 16'((sz << 8) | (int'(m_ovf) << 2) | (int'(sz == 0) << 1) | int'(sz == DEPTH));
                2'd2: val = 16'(sz);
                default: val = {15'b0, m_en};
            endcase
            if (re) n_rdata = val;
            n_rsel = re;
            pop = sz > 0 && m_en && rdy_v;
            if (we && a[1:0] == 2'd3 && wd[1]) nq = {};
            else begin
                if (pop) void'(nq.pop_front());
                if (we && a[1:0] == 2'd0) begin
                    if (sz == DEPTH) n_ovf = 1'b1;
                    else nq.push_back(wd[7:0]);
                end
            end
            if (we && a[1:0] == 2'd1 && wd[2]) n_ovf = 1'b0;
            if (we && a[1:0] == 2'd3) n_en = wd[0];
        end
        @(posedge clk);
        #1;
        m_q = nq;
        m_ovf = n_ovf;
        m_en = n_en;
        m_rdata = n_rdata;
        m_rsel = n_rsel;
    endtask

    task automatic idle();
        cycle(1'b0, 8'h00, 16'h0, 2'b00);
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        cycle(1'b0, a, d, 2'b01);
    endtask

    task automatic expect_rd(input logic [7:0] a, input logic [15:0] exp, input string nm);
        cycle(1'b0, a, 16'h0, 2'b10);
        check(nm, bus.rdata, exp);
        check({nm, "_rsel"}, {15'b0, bus.rsel}, 16'h1);
    endtask

    always @(negedge clk) begin
        if (armed) begin
            check("tx_valid", {15'b0, bus.tx_valid}, {15'b0, m_q.size() > 0 && m_en});
            if (m_q.size() > 0 && m_en) check("tx_data", {8'b0, bus.tx_data}, {8'b0, m_q[0]});
            check("rsel", {15'b0, bus.rsel}, {15'b0, m_rsel});
            check("rdata", bus.rdata, m_rdata);
        end
    end

    initial begin
        cycle(1'b1, 8'h00, 16'h0, 2'b00);
        armed = 1'b1;
        cycle(1'b1, 8'h00, 16'h0, 2'b00);
        check("reset_rdata", bus.rdata, 16'h0000);
        check("reset_valid", {15'b0, bus.tx_valid}, 16'h0);

        expect_rd(BASE + 8'd0, 16'h0000, "rd_txdata");
        expect_rd(BASE + 8'd1, 16'h0002, "rd_status");
        expect_rd(BASE + 8'd2, 16'h0000, "rd_count");
        expect_rd(BASE + 8'd3, 16'h0001, "rd_ctrl");
        idle();
        check("rsel_one_cycle", {15'b0, bus.rsel}, 16'h0);
        check("rdata_hold", bus.rdata, 16'h0001);

        rdy_v = 1'b0;
        wr(BASE, 16'h0048);
        wr(BASE, 16'h0069);
        expect_rd(BASE + 8'd2, 16'h0002, "count_hi");
        check("hi_valid", {15'b0, bus.tx_valid}, 16'h1);
        check("hi_head", {8'b0, bus.tx_data}, 16'h0048);
        rdy_v = 1'b1;
        idle();
        check("hi_second", {8'b0, bus.tx_data}, 16'h0069);
        idle();
        rdy_v = 1'b0;
        expect_rd(BASE + 8'd1, 16'h0002, "status_drained");

        for (int i = 0; i < 9; i++) wr(BASE, 16'h0030 + 16'(i));
        expect_rd(BASE + 8'd1, 16'h0805, "status_full_ovf");
        expect_rd(BASE + 8'd2, 16'h0008, "count_full");
        wr(BASE + 8'd1, 16'h0004);
        expect_rd(BASE + 8'd1, 16'h0801, "status_ovf_clr");

        rdy_v = 1'b1;
        wr(BASE, 16'h005A);
        rdy_v = 1'b0;
        expect_rd(BASE + 8'd1, 16'h0704, "status_push_pop_full");
        check("head_after_pop", {8'b0, bus.tx_data}, 16'h0031);
        cycle(1'b0, BASE + 8'd1, 16'h0004, 2'b11);
        check("rw_prewrite", bus.rdata, 16'h0704);
        expect_rd(BASE + 8'd1, 16'h0700, "status_after_rw");

        wr(BASE + 8'd3, 16'h0003);
        expect_rd(BASE + 8'd2, 16'h0000, "count_flushed");
        for (int i = 0; i < 3; i++) wr(BASE, 16'h0061 + 16'(i));
        wr(BASE + 8'd3, 16'h0000);
        check("en0_valid", {15'b0, bus.tx_valid}, 16'h0);
        rdy_v = 1'b1;
        idle();
        idle();
        expect_rd(BASE + 8'd2, 16'h0003, "count_en0");
        wr(BASE, 16'h0064);
        expect_rd(BASE + 8'd2, 16'h0004, "count_en0_push");
        wr(BASE + 8'd3, 16'h0003);
        check("flush_valid", {15'b0, bus.tx_valid}, 16'h0);
        expect_rd(BASE + 8'd3, 16'h0001, "ctrl_after_flush");
        expect_rd(BASE + 8'd2, 16'h0000, "count_after_flush");
        rdy_v = 1'b0;

        wr(BASE, 16'h0070);
        rdy_v = 1'b1;
        wr(BASE, 16'h0071);
        check("push_pop_same", {8'b0, bus.tx_data}, 16'h0071);
        rdy_v = 1'b0;
        expect_rd(BASE + 8'd2, 16'h0001, "count_push_pop");

        cycle(1'b0, 8'hEF, 16'h0041, 2'b11);
        check("miss_ef_rsel", {15'b0, bus.rsel}, 16'h0);
        cycle(1'b0, 8'hF4, 16'h0042, 2'b11);
        check("miss_f4_rsel", {15'b0, bus.rsel}, 16'h0);
        cycle(1'b0, 8'h10, 16'h0043, 2'b11);
        cycle(1'b0, 8'h00, 16'h0044, 2'b11);
        check("miss_ram_rsel", {15'b0, bus.rsel}, 16'h0);
        expect_rd(BASE + 8'd2, 16'h0001, "count_after_miss");

        for (int i = 0; i < 3; i++) wr(BASE, 16'h0072 + 16'(i));
        rdy_v = 1'b1;
        idle();
        cycle(1'b1, 8'h00, 16'h0, 2'b00);
        check("reset_mid_valid", {15'b0, bus.tx_valid}, 16'h0);
        expect_rd(BASE + 8'd2, 16'h0000, "count_after_reset");
        expect_rd(BASE + 8'd3, 16'h0001, "ctrl_after_reset");
        idle();
        @(negedge clk);
        armed = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
